spike_gate_sched: RTL

Round-robin scheduler that time-shares a single spike-gate unit among N_REQ synapse requesters. The gate registers a "spike present" flag (trigger word ≠ 0) and combinationally masks a weight word with that flag. This block selects one requester and drives the gate's trigger and weight inputs with the correct one-cycle skew. It then captures the masked result and returns it, tagged with the source index, to the downstream neuron accumulator.

---
 rtl/spike_gate_sched_if.sv | 33 +++
 rtl/spike_gate_sched.sv | 90 +++++++++
 2 files changed

// File: rtl/spike_gate_sched_if.sv
// Bundle of requester, shared-gate and result signals for the spike-gate scheduler.
// The master side is the environment (requesters plus the gate itself); the slave side is the scheduler.
interface spike_gate_sched_if #(
  parameter int N_REQ = 4,
  parameter int DW    = 4,
  parameter int CW    = 8
);
  localparam int SW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]    req;
  logic [N_REQ*DW-1:0] req_add;
  logic [N_REQ*DW-1:0] req_add2;
  logic [N_REQ-1:0]    ack;
  logic [DW-1:0]       gate_add;
  logic [DW-1:0]       gate_add2;
  logic [DW-1:0]       gate_out;
  logic                out_valid;
  logic [DW-1:0]       out_data;
  logic [SW-1:0]       out_src;
  logic                out_spike;
  logic [CW-1:0]       spike_cnt;
  logic                busy;

  modport master (
    output req, req_add, req_add2, gate_out,
    input  ack, gate_add, gate_add2, out_valid, out_data, out_src, out_spike, spike_cnt, busy
  );

  modport slave (
    input  req, req_add, req_add2, gate_out,
    output ack, gate_add, gate_add2, out_valid, out_data, out_src, out_spike, spike_cnt, busy
  );
endinterface

// File: rtl/spike_gate_sched.sv
// Round-robin scheduler time-sharing one spike-gate unit among N_REQ requesters,
// returning each masked weight tagged with its source and a saturating spike count.
module spike_gate_sched #(
  parameter int N_REQ = 4,
  parameter int DW    = 4,
  parameter int CW    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  spike_gate_sched_if.slave   bus
);
  localparam int SW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

  state_t        state, next_state;
  logic [SW-1:0] last_grant;
  logic [SW-1:0] pick;
  logic [SW-1:0] cand;
  logic          found;

  // Search starts one past the previous winner so every holder of req is reached within N_REQ grants.
  always_comb begin
    found = 1'b0;
    pick  = last_grant;
    cand  = last_grant;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = SW'((int'(last_grant) + k) % N_REQ);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (found) next_state = ISSUE;
      ISSUE:   next_state = CAPTURE;
      CAPTURE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // gate_add doubles as the latched trigger, so the spike decision ignores the weight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant    <= SW'(N_REQ - 1);
      bus.gate_add  <= '0;
      bus.gate_add2 <= '0;
      bus.out_data  <= '0;
      bus.out_src   <= '0;
      bus.out_spike <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.ack       <= '0;
      bus.spike_cnt <= '0;
    end else begin
      bus.ack       <= '0;
      bus.out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            bus.gate_add  <= bus.req_add[pick*DW +: DW];
            bus.gate_add2 <= bus.req_add2[pick*DW +: DW];
            last_grant    <= pick;
          end
        end
        CAPTURE: begin
          bus.out_data  <= bus.gate_out;
          bus.out_src   <= last_grant;
          bus.out_spike <= |bus.gate_add;
          bus.out_valid <= 1'b1;
          bus.ack       <= {{(N_REQ-1){1'b0}}, 1'b1} << last_grant;
          if (|bus.gate_add && bus.spike_cnt != CNT_MAX)
            bus.spike_cnt <= bus.spike_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
endmodule
